// File: rtl/video_capture.sv
// Raster capture: measures hs/vs/de timing and streams whole frames as {sof,eol,rgb} through a FWFT FIFO.
// Latency: a pixel is pushed on the next ce_pix and is visible on out_valid 1 clk after the push.
// Backpressure: out_ready stalls the FIFO head; a push into a full FIFO with no pop is dropped and sets overflow.

module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    output logic          drop,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;

    // A pop in the same clk frees the slot, so a push on a full FIFO still lands.
    assign pop_vld = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_vld && pop_rdy;
    assign do_push = push_vld && (!full || do_pop);
    assign drop    = push_vld && full && !do_pop;
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module video_capture #(
    parameter int   FIFO_AW = 4,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0,
    parameter int   CNT_W   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    input  logic             enable,
    input  logic             clr_ovf,
    output logic [23:0]      out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] v_total,
    output logic             timing_ok,
    output logic             capturing,
    output logic             overflow
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE} state_t;
    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] rgb;
    } pix_t;

    state_t           state, state_nxt;
    logic             hs_q, vs_q, de_q;
    logic             hs_lead, vs_lead, de_rise, de_fall;
    logic [CNT_W-1:0] h_cnt, de_cnt, v_cnt, va_cnt;
    logic [CNT_W-1:0] ht_nxt, ha_nxt, ht_prev, ha_prev;
    logic             take, flush;
    logic [23:0]      hold_rgb;
    logic             hold_vld, hold_sof, sof_pend;
    pix_t             push_dat, head;
    logic             push_vld, fifo_drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hs_lead = ce_pix && (hs == HS_POL) && (hs_q != HS_POL);
    assign vs_lead = ce_pix && (vs == VS_POL) && (vs_q != VS_POL);
    assign de_rise = ce_pix && de && !de_q;
    assign de_fall = ce_pix && !de && de_q;
    assign ht_nxt  = hs_lead ? h_cnt : h_total;
    assign ha_nxt  = de_fall ? de_cnt : h_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else if (ce_pix) begin
            hs_q <= hs;
            vs_q <= vs;
            de_q <= de;
        end
    end

    // Timing counters; the frame snapshot is compared against the previous one on vs_lead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            de_cnt    <= '0;
            v_cnt     <= '0;
            va_cnt    <= '0;
            h_total   <= '0;
            h_active  <= '0;
            v_total   <= '0;
            v_active  <= '0;
            ht_prev   <= '0;
            ha_prev   <= '0;
            timing_ok <= 1'b0;
        end else begin
            if (ce_pix)      h_cnt  <= hs_lead ? CNT_W'(1) : sat_inc(h_cnt);
            if (hs_lead)     h_total <= h_cnt;
            if (ce_pix && de) de_cnt <= de_q ? sat_inc(de_cnt) : CNT_W'(1);
            if (de_fall)     h_active <= de_cnt;
            if (vs_lead) begin
                v_cnt     <= hs_lead ? CNT_W'(1) : '0;
                va_cnt    <= de_rise ? CNT_W'(1) : '0;
                v_total   <= v_cnt;
                v_active  <= va_cnt;
                ht_prev   <= ht_nxt;
                ha_prev   <= ha_nxt;
                timing_ok <= (ht_nxt == ht_prev) && (ha_nxt == ha_prev) &&
                             (v_cnt == v_total) && (va_cnt == v_active) &&
                             (ht_nxt != '0) && (v_cnt != '0);
            end else begin
                if (hs_lead) v_cnt  <= sat_inc(v_cnt);
                if (de_rise) va_cnt <= sat_inc(va_cnt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Arming is immediate; entering and leaving CAPTURE only happens at frame boundaries.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (enable) state_nxt = ST_ARMED;
            ST_ARMED:   if (vs_lead) state_nxt = enable ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: if (vs_lead && !enable) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign capturing = (state == ST_CAPTURE);

    // One-pixel hold lets the last pixel of a line be tagged eol once de drops.
    assign take     = ce_pix && de && (state == ST_CAPTURE);
    assign flush    = ce_pix && !de && hold_vld;
    assign push_vld = (take && hold_vld) || flush;
    assign push_dat = {hold_sof, flush, hold_rgb};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_rgb <= '0;
            hold_vld <= 1'b0;
            hold_sof <= 1'b0;
            sof_pend <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (vs_lead && state_nxt == ST_CAPTURE) sof_pend <= 1'b1;
            else if (take)                          sof_pend <= 1'b0;
            if (take) begin
                hold_rgb <= {r, g, b};
                hold_vld <= 1'b1;
                hold_sof <= sof_pend;
            end else if (flush) begin
                hold_vld <= 1'b0;
            end
            if (fifo_drop)    overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    sync_fifo #(.DW($bits(pix_t)), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .drop     (fifo_drop),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head)
    );

    assign out_data = head.rgb;
    assign out_sof  = head.sof;
    assign out_eol  = head.eol;
endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture: random pixel data and ce_pix gaps, expected stream and timing from raster geometry.
module tb_video_capture;
    localparam int CNT_W = 12;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ce_pix = 1'b0;
    logic             hs = 1'b1;
    logic             vs = 1'b1;
    logic             de = 1'b0;
    logic [7:0]       r = '0, g = '0, b = '0;
    logic             enable = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [23:0]      out_data;
    logic             out_sof, out_eol, out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] h_active, h_total, v_active, v_total;
    logic             timing_ok, capturing, overflow;

    int total = 0;
    int bad = 0;
    int valid_seen = 0;
    logic [25:0] got_q[$];
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    video_capture #(.FIFO_AW(4), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
        .r(r), .g(g), .b(b), .enable(enable), .clr_ovf(clr_ovf),
        .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .out_valid(out_valid), .out_ready(out_ready),
        .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
        .timing_ok(timing_ok), .capturing(capturing), .overflow(overflow)
    );

    // Consumer: the head seen at negedge with ready high is the one popped at the next posedge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            valid_seen++;
            if (out_ready) got_q.push_back({out_sof, out_eol, out_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic drive_px(input logic h, input logic v, input logic d,
                            input logic [23:0] px, input bit rdy_set);
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            ce_pix = 1'b0;
            hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            {r, g, b} = 24'($urandom);
            @(posedge clk); #1;
        end
        ce_pix = 1'b1; hs = h; vs = v; de = d; {r, g, b} = px;
        if (rdy_set) out_ready = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
    endtask

    task automatic apply_reset();
        ce_pix = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b0;
        enable = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete(); exp_q.delete(); valid_seen = 0;
        repeat (3) drive_px(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    endtask

    // Frame boundary only: sync leading edges with no active video.
    task automatic vs_pulse();
        drive_px(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        drive_px(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        drive_px(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        drive_px(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    endtask

    // Lines 0-1 carry vs, pixels 0-1 carry hs, active video at lines 3.. and pixels 4..
    task automatic do_frame(input int hact, input int htot, input int vact, input int vtot,
                            input bit cap, input bit chk_ok, input bit exp_ok, input bit exp_capt,
                            input int drop_ln, input int rdy_idx);
        bit first;
        int nact;
        bit act;
        logic [23:0] pix;
        first = 1'b1;
        nact = 0;
        for (int ln = 0; ln < vtot; ln++) begin
            for (int px = 0; px < htot; px++) begin
                act = (ln >= 3) && (ln < 3 + vact) && (px >= 4) && (px < 4 + hact);
                pix = 24'($urandom);
                if (ln == drop_ln && px == 0) enable = 1'b0;
                drive_px(px >= 2, ln >= 2, act, pix, act && (nact == rdy_idx));
                if (act) begin
                    if (cap) exp_q.push_back({first, px == 3 + hact, pix});
                    first = 1'b0;
                    nact++;
                end
                if (ln == 0 && px == 0) begin
                    total++;
                    if (capturing !== exp_capt) begin
                        bad++;
                        $display("FAIL frame_capturing got=%0b want=%0b", capturing, exp_capt);
                    end
                    if (chk_ok) begin
                        total++;
                        if (timing_ok !== exp_ok) begin
                            bad++;
                            $display("FAIL frame_timing_ok got=%0b want=%0b", timing_ok, exp_ok);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++;
        if ({out_sof, out_eol, out_data} !== 26'd0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {out_sof, out_eol, out_data});
        end
        total++;
        if ({h_total, h_active, v_total, v_active} !== 48'd0) begin
            bad++; $display("FAIL reset_timing got=%h want=0", {h_total, h_active, v_total, v_active});
        end
        total++;
        if ({timing_ok, capturing, overflow} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {timing_ok, capturing, overflow});
        end
    endtask

    task automatic test_measure();
        apply_reset();
        out_ready = 1'b1;
        do_frame(16, 24, 6, 10, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
        do_frame(16, 24, 6, 10, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
        vs_pulse();
        total++;
        if (h_active !== 12'd16) begin bad++; $display("FAIL meas_h_active got=%0d want=16", h_active); end
        total++;
        if (h_total !== 12'd24) begin bad++; $display("FAIL meas_h_total got=%0d want=24", h_total); end
        total++;
        if (v_active !== 12'd6) begin bad++; $display("FAIL meas_v_active got=%0d want=6", v_active); end
        total++;
        if (v_total !== 12'd10) begin bad++; $display("FAIL meas_v_total got=%0d want=10", v_total); end
        total++;
        if (timing_ok !== 1'b1) begin bad++; $display("FAIL meas_timing_ok got=%0b want=1", timing_ok); end
        total++;
        if (valid_seen != 0) begin bad++; $display("FAIL meas_no_output got=%0d want=0", valid_seen); end
    endtask

    task automatic test_capture();
        apply_reset();
        enable = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        do_frame(8, 14, 4, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        drain(32);
        total++;
        if (got_q.size() != 32 || exp_q.size() != 32) begin
            bad++; $display("FAIL cap_count got=%0d want=32 (model %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL cap_pixel[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL cap_overflow got=%0b want=0", overflow); end
    endtask

    task automatic test_overflow();
        apply_reset();
        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
        do_frame(20, 26, 1, 5, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", overflow); end
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        out_ready = 1'b1;
        drain(DEPTH);
        total++;
        if (got_q.size() != DEPTH) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", got_q.size(), DEPTH); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ovf_pixel[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", overflow); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
        do_frame(20, 26, 1, 5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 17);
        drain(20);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%0b want=0", overflow); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b_pixel[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        enable = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        do_frame(8, 14, 4, 8, 1'b1, 1'b0, 1'b0, 1'b1, 4, -1);
        do_frame(8, 14, 4, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        drain(32);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL drop_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL drop_pixel[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timing_change();
        int htots[5] = '{20, 20, 20, 22, 22};
        bit exp_ok;
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            // Frame start measures the previous frame: stable only if it matches the one before it.
            exp_ok = (f >= 2) && (htots[f-1] == htots[f-2]);
            do_frame(8, htots[f], 4, 8, 1'b0, 1'b1, exp_ok, 1'b0, -1, -1);
            total++;
            if (h_total !== 12'(htots[f])) begin
                bad++; $display("FAIL chg_h_total[%0d] got=%0d want=%0d", f, h_total, htots[f]);
            end
        end
        vs_pulse();
        total++;
        if (timing_ok !== 1'b1) begin bad++; $display("FAIL chg_final_ok got=%0b want=1", timing_ok); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
        vs_pulse();
        repeat (6) drive_px(1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0);
        total++;
        if (out_valid !== 1'b1 || capturing !== 1'b1) begin
            bad++; $display("FAIL arst_pre got valid=%0b capt=%0b want 1 1", out_valid, capturing);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b want=0", out_valid); end
        total++;
        if ({out_sof, out_eol, out_data} !== 26'd0) begin
            bad++; $display("FAIL arst_data got=%h want=0", {out_sof, out_eol, out_data});
        end
        total++;
        if ({h_total, h_active, v_total, v_active} !== 48'd0) begin
            bad++; $display("FAIL arst_timing got=%h want=0", {h_total, h_active, v_total, v_active});
        end
        total++;
        if ({timing_ok, capturing, overflow} !== 3'b000) begin
            bad++; $display("FAIL arst_flags got=%b want=000", {timing_ok, capturing, overflow});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        valid_seen = 0;
        out_ready = 1'b1;
        repeat (6) drive_px(1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0);
        drive_px(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        repeat (4) @(posedge clk); #1;
        total++;
        if (capturing !== 1'b0 || valid_seen != 0) begin
            bad++; $display("FAIL arst_no_resume got capt=%0b outs=%0d want 0 0", capturing, valid_seen);
        end
        vs_pulse();
        total++;
        if (capturing !== 1'b1) begin bad++; $display("FAIL arst_resume got=%0b want=1", capturing); end
    endtask

    initial begin
        test_reset();
        test_measure();
        test_capture();
        test_overflow();
        test_back_to_back();
        test_enable_drop();
        test_timing_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
